program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Writer side of the minicomputer's 256 x 16 program memory.
- Accepts a byte stream over a valid/ready handshake, assembles 16-bit instructions high byte first, and writes them sequentially into program RAM from address 0.
- Verifies a trailing checksum.
- Holds the CPU in reset until a load completes cleanly.

Parameters:
- ADDR_WIDTH, 8, program memory address width (256 words).
- DATA_WIDTH, 16, instruction width; stream is exactly 2 bytes per word.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high; forces all state and outputs to reset values immediately.
- start  input  1  begins a load session; sampled only in IDLE, DONE or ERR.
- byte_in  input  8  stream byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader can accept a byte this cycle.
- mem_write_enable  output  1  one-cycle write strobe to program RAM.
- mem_address  output  ADDR_WIDTH  write pointer / write address.
- mem_data  output  DATA_WIDTH  assembled instruction.
- cpu_hold  output  1  drives the CPU reset/stall; 1 = CPU held.
- busy  output  1  load session in progress.
- done  output  1  load completed, checksum correct.
- error  output  1  load aborted or checksum mismatch.
- words_loaded  output  8  number of words written this session.

Behaviour:
- Reset values:
  - byte_ready=0, mem_write_enable=0, mem_address=0, mem_data=0.
  - cpu_hold=1, busy=0, done=0, error=0, words_loaded=0.
  - State goes to IDLE.
- Stream format: LEN byte N (1..255), then 2N data bytes (hi, lo per word), then CHK byte.
  - CHK = 8-bit modulo-256 sum of the 2N data bytes only; LEN and CHK are excluded.
- A byte is accepted on a posedge where byte_valid=1 and byte_ready=1.
  - byte_ready is 1 exactly in states LEN, HI, LO and CHK.
- States:
  - IDLE: start=1 -> LEN. Clears mem_address, words_loaded, the checksum accumulator, done and error. Sets busy=1.
  - LEN: accept N.
    - N=0 -> ERR.
    - Otherwise latch N -> HI.
  - HI: accept byte -> mem_data[15:8]; add to checksum -> LO.
  - LO: accept byte -> mem_data[7:0]; add to checksum -> WRITE.
  - WRITE (1 cycle):
    - mem_write_enable=1 with the current mem_address/mem_data; byte_ready=0.
    - At the end of the cycle, words_loaded+1.
    - If words_loaded+1 == N -> CHK (mem_address holds the last written address).
    - Else mem_address+1 -> HI.
  - CHK: accept byte.
    - Equal to accumulator -> DONE.
    - Else -> ERR.
  - DONE: done=1, busy=0, cpu_hold=0.
  - ERR: error=1, busy=0, cpu_hold=1.
  - Restart from DONE or ERR: start=1 -> same actions as IDLE+start. done/error clear and cpu_hold reasserts the same cycle the session begins.
- Latency and ordering:
  - Write strobe appears the cycle after the low byte is accepted.
  - Minimum session length is 1 + 3N + 1 cycles after start.
- cpu_hold is 1 in every state except DONE.
- start while busy is ignored.
- byte_valid while byte_ready=0 is not consumed; the source holds the byte.
- Address never wraps: N ≤ 255 keeps mem_address ≤ 0xFE.
- Words already written before an error or reset remain in RAM. The loader does not erase them.
- Reset mid-session:
  - Immediate return to IDLE.
  - Any in-progress write strobe drops asynchronously.
  - Partial words are discarded.
- Checksum arithmetic is 8-bit wrap-around; carries are dropped.

Test Plan:
- Nominal load:
  - Stimulus: start; bytes 02,71,05,23,12,AB.
  - Required: writes (addr 00, data 7105) then (addr 01, data 2312), one strobe cycle each; done=1, error=0, cpu_hold=0, words_loaded=2, busy=0.
- Bad checksum:
  - Stimulus: same stream with CHK=AC.
  - Required: both writes occur; error=1, done=0, cpu_hold=1.
- Zero length:
  - Stimulus: start; byte 00.
  - Required: ERR the cycle after acceptance; no mem_write_enable; words_loaded=0.
- Backpressure and gaps:
  - Stimulus: nominal stream with byte_valid low 3 cycles between bytes, and byte 23 presented during the WRITE cycle.
  - Required: 23 not accepted while byte_ready=0, accepted the next cycle; identical memory writes and done=1.
- Reset mid-load:
  - Stimulus: assert reset after bytes 02,71,05 are accepted.
  - Required: all outputs reach reset values without a clock edge; a following start plus a full nominal stream rewrites address 00 and completes with done=1.
- Restart and ignored start:
  - Stimulus: pulse start during HI; later pulse start in DONE.
  - Required: first start has no effect; second clears done, sets cpu_hold=1 and busy=1, mem_address=0, and a new session runs correctly.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: byte-stream writer for the 256 x 16 program memory.
// Frames are LEN, then LEN pairs of (hi, lo) instruction bytes, then an
// 8-bit wrap-around sum of the data bytes. The CPU stays held until a
// frame has been written and its checksum matches.
module program_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [7:0]            words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_WRITE = 3'd4,
        S_CHK   = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [7:0]            r_len;
    logic [7:0]            r_csum;
    logic [7:0]            r_words;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;

    logic                  r_byte_ready;
    logic                  r_write_enable;
    logic                  r_cpu_hold;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;

    logic                  w_accept;
    logic [7:0]            w_words_inc;
    logic                  w_last_word;

    // Modulo-256 checksum step; carries out of bit 7 are dropped.
    function automatic logic [7:0] f_csum_add(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] s;
        s = a + b;
        return s;
    endfunction

    assign w_accept    = byte_valid & r_byte_ready;
    assign w_words_inc = r_words + 8'd1;
    assign w_last_word = (w_words_inc == r_len);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; start only matters while no session is running.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    w_next_state = S_LEN;
                end else begin
                    w_next_state = r_state;
                end
            end
            S_LEN: begin
                if (w_accept) begin
                    if (byte_in == 8'd0) begin
                        w_next_state = S_ERR;
                    end else begin
                        w_next_state = S_HI;
                    end
                end else begin
                    w_next_state = S_LEN;
                end
            end
            S_HI: begin
                if (w_accept) begin
                    w_next_state = S_LO;
                end else begin
                    w_next_state = S_HI;
                end
            end
            S_LO: begin
                if (w_accept) begin
                    w_next_state = S_WRITE;
                end else begin
                    w_next_state = S_LO;
                end
            end
            S_WRITE: begin
                if (w_last_word) begin
                    w_next_state = S_CHK;
                end else begin
                    w_next_state = S_HI;
                end
            end
            S_CHK: begin
                if (w_accept) begin
                    if (byte_in == r_csum) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_ERR;
                    end
                end else begin
                    w_next_state = S_CHK;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Datapath: length latch, word assembly, checksum, write pointer and word count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_len   <= 8'd0;
            r_csum  <= 8'd0;
            r_words <= 8'd0;
            r_addr  <= {ADDR_WIDTH{1'b0}};
            r_data  <= {DATA_WIDTH{1'b0}};
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_csum  <= 8'd0;
                        r_words <= 8'd0;
                        r_addr  <= {ADDR_WIDTH{1'b0}};
                    end
                end
                S_LEN: begin
                    if (w_accept) begin
                        r_len <= byte_in;
                    end
                end
                S_HI: begin
                    if (w_accept) begin
                        r_data[DATA_WIDTH-1 -: 8] <= byte_in;
                        r_csum                    <= f_csum_add(r_csum, byte_in);
                    end
                end
                S_LO: begin
                    if (w_accept) begin
                        r_data[7:0] <= byte_in;
                        r_csum      <= f_csum_add(r_csum, byte_in);
                    end
                end
                S_WRITE: begin
                    r_words <= w_words_inc;
                    // The pointer stays on the last written word once the frame is complete.
                    if (!w_last_word) begin
                        r_addr <= r_addr + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status outputs registered from the state being entered, so they track the FSM without glitches.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_byte_ready   <= 1'b0;
            r_write_enable <= 1'b0;
            r_cpu_hold     <= 1'b1;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_byte_ready   <= (w_next_state == S_LEN) || (w_next_state == S_HI) ||
                              (w_next_state == S_LO)  || (w_next_state == S_CHK);
            r_write_enable <= (w_next_state == S_WRITE);
            r_cpu_hold     <= (w_next_state != S_DONE);
            r_busy         <= (w_next_state == S_LEN) || (w_next_state == S_HI) ||
                              (w_next_state == S_LO)  || (w_next_state == S_WRITE) ||
                              (w_next_state == S_CHK);
            r_done         <= (w_next_state == S_DONE);
            r_error        <= (w_next_state == S_ERR);
        end
    end

    assign byte_ready       = r_byte_ready;
    assign mem_write_enable = r_write_enable;
    assign mem_address      = r_addr;
    assign mem_data         = r_data;
    assign cpu_hold         = r_cpu_hold;
    assign busy             = r_busy;
    assign done             = r_done;
    assign error            = r_error;
    assign words_loaded     = r_words;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench for program_loader. Expected RAM writes
// are queued when a frame is driven and popped by a write monitor.
module tb_program_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_write_enable;
    logic [7:0]  mem_address;
    logic [15:0] mem_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  words_loaded;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic        prev_we = 1'b0;
    logic [15:0] tb_words [0:255];

    program_loader dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .byte_in          (byte_in),
        .byte_valid       (byte_valid),
        .byte_ready       (byte_ready),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_data         (mem_data),
        .cpu_hold         (cpu_hold),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .words_loaded     (words_loaded)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Cycle counter for latency measurement.
    always @(posedge clock) cyc++;

    // Write monitor: every strobe must match the head of the scoreboard and last one cycle.
    always @(negedge clock) begin
        if (mem_write_enable === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h, required no write", mem_address, mem_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({mem_address, mem_data} !== {mon_e.addr, mon_e.data}) begin
                    errors++;
                    $display("FAIL write_value got addr=%h data=%h, required addr=%h data=%h",
                             mem_address, mem_data, mon_e.addr, mon_e.data);
                end
            end
            checks++;
            if (prev_we !== 1'b0) begin
                errors++;
                $display("FAIL strobe_width got strobe on consecutive cycles, required single cycle");
            end
        end
        prev_we = mem_write_enable;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Present a byte until accepted; returns on the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n          = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout byte=%h not accepted within 100 cycles", b);
        end
        @(negedge clock);
        byte_valid = 1'b0;
    endtask

    // Drive a frame from tb_words[0..nw-1], queuing its writes; chk_xor corrupts the checksum.
    task automatic run_session(input int nw, input logic [7:0] chk_xor, input int gap, input bit do_start);
        logic [7:0] sum;
        wr_t        w;
        sum = 8'd0;
        for (int i = 0; i < nw; i++) begin
            w.addr = i[7:0];
            w.data = tb_words[i];
            exp_q.push_back(w);
            sum = sum + tb_words[i][15:8] + tb_words[i][7:0];
        end
        if (do_start) pulse_start();
        idle(gap);
        send_byte(nw[7:0]);
        for (int i = 0; i < nw; i++) begin
            idle(gap);
            send_byte(tb_words[i][15:8]);
            idle(gap);
            send_byte(tb_words[i][7:0]);
        end
        idle(gap);
        send_byte(sum ^ chk_xor);
    endtask

    task automatic set_nominal();
        tb_words[0] = 16'h7105;
        tb_words[1] = 16'h2312;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        #1;
        checks++;
        if ({byte_ready, mem_write_enable, mem_address, mem_data, cpu_hold, busy, done, error, words_loaded}
            !== {1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_values got rdy=%b we=%b a=%h d=%h hold=%b busy=%b done=%b err=%b wl=%h",
                     byte_ready, mem_write_enable, mem_address, mem_data, cpu_hold, busy, done, error, words_loaded);
        end
        idle(3);
        reset = 1'b0;
        idle(2);
        checks++;
        if ({byte_ready, busy, cpu_hold} !== 3'b001) begin
            errors++;
            $display("FAIL idle_after_reset got rdy=%b busy=%b hold=%b, required 0 0 1", byte_ready, busy, cpu_hold);
        end
    endtask

    task automatic test_nominal();
        int t0;
        set_nominal();
        exp_q.push_back('{addr: 8'h00, data: 16'h7105});
        exp_q.push_back('{addr: 8'h01, data: 16'h2312});
        pulse_start();
        t0 = cyc;
        checks++;
        if ({busy, byte_ready, cpu_hold} !== 3'b111) begin
            errors++;
            $display("FAIL nominal_start got busy=%b rdy=%b hold=%b, required 1 1 1", busy, byte_ready, cpu_hold);
        end
        send_byte(8'h02);
        send_byte(8'h71);
        send_byte(8'h05);
        send_byte(8'h23);
        send_byte(8'h12);
        send_byte(8'hAB);
        checks++;
        if ({done, error, cpu_hold, busy, words_loaded, mem_address} !== {4'b1000, 8'd2, 8'h01}) begin
            errors++;
            $display("FAIL nominal_status got done=%b err=%b hold=%b busy=%b wl=%0d a=%h, required 1 0 0 0 2 01",
                     done, error, cpu_hold, busy, words_loaded, mem_address);
        end
        checks++;
        if (cyc - t0 !== 8) begin
            errors++;
            $display("FAIL nominal_latency got %0d cycles, required 8", cyc - t0);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL nominal_writes got %0d missing writes, required 0", exp_q.size());
        end
    endtask

    task automatic test_bad_checksum();
        set_nominal();
        run_session(2, 8'h07, 0, 1'b1);
        checks++;
        if ({done, error, cpu_hold, busy, words_loaded} !== {4'b0110, 8'd2}) begin
            errors++;
            $display("FAIL badchk_status got done=%b err=%b hold=%b busy=%b wl=%0d, required 0 1 1 0 2",
                     done, error, cpu_hold, busy, words_loaded);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL badchk_writes got %0d missing writes, required 0", exp_q.size());
        end
    endtask

    task automatic test_zero_len();
        pulse_start();
        send_byte(8'h00);
        checks++;
        if ({error, done, busy, cpu_hold, byte_ready, words_loaded} !== {5'b10010, 8'd0}) begin
            errors++;
            $display("FAIL zerolen_status got err=%b done=%b busy=%b hold=%b rdy=%b wl=%0d, required 1 0 0 1 0 0",
                     error, done, busy, cpu_hold, byte_ready, words_loaded);
        end
        idle(3);
    endtask

    task automatic test_backpressure();
        set_nominal();
        exp_q.push_back('{addr: 8'h00, data: 16'h7105});
        exp_q.push_back('{addr: 8'h01, data: 16'h2312});
        pulse_start();
        idle(3);
        send_byte(8'h02);
        idle(3);
        send_byte(8'h71);
        idle(3);
        send_byte(8'h05);
        byte_in    = 8'h23;
        byte_valid = 1'b1;
        checks++;
        if ({byte_ready, mem_write_enable} !== 2'b01) begin
            errors++;
            $display("FAIL bp_write_cycle got rdy=%b we=%b, required 0 1", byte_ready, mem_write_enable);
        end
        @(negedge clock);
        checks++;
        if ({byte_ready, mem_data, words_loaded} !== {1'b1, 16'h7105, 8'd1}) begin
            errors++;
            $display("FAIL bp_not_consumed got rdy=%b d=%h wl=%0d, required 1 7105 1", byte_ready, mem_data, words_loaded);
        end
        send_byte(8'h23);
        idle(3);
        send_byte(8'h12);
        idle(3);
        send_byte(8'hAB);
        checks++;
        if ({done, error, exp_q.size() == 0} !== 3'b101) begin
            errors++;
            $display("FAIL bp_status got done=%b err=%b pending=%0d, required 1 0 0", done, error, exp_q.size());
        end
    endtask

    task automatic test_mid_reset();
        set_nominal();
        exp_q.push_back('{addr: 8'h00, data: 16'h7105});
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h71);
        byte_in    = 8'h05;
        byte_valid = 1'b1;
        @(posedge clock);
        #1;
        byte_valid = 1'b0;
        checks++;
        if (mem_write_enable !== 1'b1) begin
            errors++;
            $display("FAIL midrst_strobe got we=%b, required 1", mem_write_enable);
        end
        // The queued write is abandoned along with the strobe.
        void'(exp_q.pop_front());
        reset = 1'b1;
        #1;
        checks++;
        if ({byte_ready, mem_write_enable, mem_address, mem_data, cpu_hold, busy, done, error, words_loaded}
            !== {1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL midrst_values got rdy=%b we=%b a=%h d=%h hold=%b busy=%b done=%b err=%b wl=%h",
                     byte_ready, mem_write_enable, mem_address, mem_data, cpu_hold, busy, done, error, words_loaded);
        end
        @(negedge clock);
        reset = 1'b0;
        idle(1);
        run_session(2, 8'h00, 0, 1'b1);
        checks++;
        if ({done, error, words_loaded, exp_q.size() == 0} !== {2'b10, 8'd2, 1'b1}) begin
            errors++;
            $display("FAIL midrst_reload got done=%b err=%b wl=%0d pending=%0d, required 1 0 2 0",
                     done, error, words_loaded, exp_q.size());
        end
    endtask

    task automatic test_restart();
        set_nominal();
        exp_q.push_back('{addr: 8'h00, data: 16'h7105});
        exp_q.push_back('{addr: 8'h01, data: 16'h2312});
        pulse_start();
        send_byte(8'h02);
        pulse_start();
        checks++;
        if ({busy, byte_ready, mem_address, words_loaded} !== {2'b11, 8'h00, 8'd0}) begin
            errors++;
            $display("FAIL ignored_start got busy=%b rdy=%b a=%h wl=%0d, required 1 1 00 0",
                     busy, byte_ready, mem_address, words_loaded);
        end
        send_byte(8'h71);
        send_byte(8'h05);
        send_byte(8'h23);
        send_byte(8'h12);
        send_byte(8'hAB);
        checks++;
        if ({done, error} !== 2'b10) begin
            errors++;
            $display("FAIL restart_first got done=%b err=%b, required 1 0", done, error);
        end
        start = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if ({done, error, cpu_hold, busy, mem_address, words_loaded} !== {4'b0011, 8'h00, 8'd0}) begin
            errors++;
            $display("FAIL restart_clear got done=%b err=%b hold=%b busy=%b a=%h wl=%0d, required 0 0 1 1 00 0",
                     done, error, cpu_hold, busy, mem_address, words_loaded);
        end
        @(negedge clock);
        start = 1'b0;
        tb_words[0] = 16'hBEEF;
        tb_words[1] = 16'h0001;
        tb_words[2] = 16'hFF80;
        run_session(3, 8'h00, 0, 1'b0);
        checks++;
        if ({done, error, words_loaded, mem_address, exp_q.size() == 0} !== {2'b10, 8'd3, 8'h02, 1'b1}) begin
            errors++;
            $display("FAIL restart_second got done=%b err=%b wl=%0d a=%h pending=%0d, required 1 0 3 02 0",
                     done, error, words_loaded, mem_address, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 6; i++) tb_words[i] = 16'($urandom);
            run_session(6, 8'h00, s, 1'b1);
            checks++;
            if ({done, error, cpu_hold, words_loaded, exp_q.size() == 0} !== {3'b100, 8'd6, 1'b1}) begin
                errors++;
                $display("FAIL b2b_session%0d got done=%b err=%b hold=%b wl=%0d pending=%0d, required 1 0 0 6 0",
                         s, done, error, cpu_hold, words_loaded, exp_q.size());
            end
        end
    endtask

    // Test sequence.
    initial begin
        test_reset();
        test_nominal();
        test_bad_checksum();
        test_zero_len();
        test_backpressure();
        test_mid_reset();
        test_restart();
        test_back_to_back();
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
